// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the fetch PC, reads instruction_memory combinationally,
// and buffers {pc, word} pairs in a prefetch FIFO drained by decode.
// Optional: IFETCH_HALT_ON_ZERO_EN stops fetch when a zero word is read.
module instruction_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] Add,
  input  logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fentry_t;

  fentry_t [DEPTH-1:0] fifo;
  logic [PW-1:0]       head, tail;
  logic [PW:0]         count;
  logic [31:0]         fpc;
  logic                pop, push, room;
  logic                unused_lsb;

  assign Add         = fpc;
  assign instr_valid = (count != '0);
  assign instr_out   = fifo[head].instr;
  assign pc_out      = fifo[head].pc;
  assign pop         = instr_valid & instr_ready;
  // A full FIFO still has room when the head leaves this cycle.
  assign room        = (count < FULL) | pop;
  assign unused_lsb  = ^redirect_pc[1:0];

`ifdef IFETCH_HALT_ON_ZERO_EN
  logic halt_set, halted_int;

  always_comb begin
    push     = 1'b0;
    halt_set = 1'b0;
    if (!redirect && !halted_int && room) begin
      if (Instr == 32'h0) halt_set = 1'b1;
      else                push     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) halted_int <= 1'b0;
    else if (halt_set)   halted_int <= 1'b1;
  end

  assign halted = halted_int;
`else
  assign push   = !redirect && room;
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc   <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      fifo  <= '0;
    end else if (redirect) begin
      // Any same-cycle pop is dropped along with the rest of the FIFO.
      fpc   <= {redirect_pc[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[tail] <= '{pc: fpc, instr: Instr};
        tail       <= tail + 1'b1;
        fpc        <= fpc + 32'd4;
      end
      if (pop) head <= head + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end
endmodule
